// File: rtl/des_pkg.sv
// des_pkg: shared definitions for the serial DES S-box datapath.
//   SBOX        - eight DES S-box tables, [sel][row] gives a 64-bit row of
//                 sixteen 4-bit entries, column 0 in the top nibble
//   sbox_entry  - pulls one 4-bit entry out of SBOX by (sel, row, col)
//   seq_state_e - sequencer FSM states
package des_pkg;

  localparam int SBOX_COUNT = 8;
  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  // Rows are written left to right as column 0..15, one hex digit per entry.
  localparam logic [63:0] SBOX [SBOX_COUNT][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
      64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
      64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1,
      64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
      64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
      64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
      64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
      64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
      64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  function automatic logic [3:0] sbox_entry(input logic [2:0] sel,
                                            input logic [1:0] row,
                                            input logic [3:0] col);
    logic [63:0] line;
    line = SBOX[sel][row];
    // column 0 sits in the top nibble, so bit offset is 4*(15-col)
    return line[{~col, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/des_sbox_sequencer_if.sv
// des_sbox_sequencer_if: valid/ready stream of W-bit words.
//   valid, data - driven by the producer (master)
//   ready       - driven by the consumer (slave)
interface des_sbox_sequencer_if #(parameter int W = 32) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/des_sbox_rom.sv
// des_sbox_rom: single shared S-box lookup.
//   clk, rst_n - used only when REG_ROM=1
//   sel        - which S-box (0 = S1 .. 7 = S8)
//   addr       - 6-bit S-box input; row = {addr[5], addr[0]}, col = addr[4:1]
//   dout       - 4-bit S-box output, combinational or one cycle late
module des_sbox_rom
  import des_pkg::*;
#(
  parameter bit REG_ROM = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            sel,
  input  logic [SBOX_IN_W-1:0]  addr,
  output logic [SBOX_OUT_W-1:0] dout
);

  logic [SBOX_OUT_W-1:0] lut;

  assign lut = sbox_entry(sel, {addr[5], addr[0]}, addr[4:1]);

  generate
    if (REG_ROM) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout <= '0;
        else        dout <= lut;
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout = lut;
    end
  endgenerate

endmodule

// File: rtl/des_sbox_sequencer.sv
// des_sbox_sequencer: runs the eight S-box substitutions of a DES round
// through one shared lookup, one S-box per cycle.
//   clk, rst_n - clock, async active-low reset
//   in_if      - 48-bit post-XOR word in (S1 in [47:42] .. S8 in [5:0])
//   out_if     - 32-bit substitution result out (S1 in [31:28] .. S8 in [3:0])
//   busy       - high whenever not idle
// Only one word is in flight; a new word is taken only after the result
// has been handed off.
module des_sbox_sequencer
  import des_pkg::*;
#(
  parameter bit REG_ROM = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  des_sbox_sequencer_if.slave    in_if,
  des_sbox_sequencer_if.master   out_if,
  output logic                   busy
);

  seq_state_e state, state_nxt;
  logic [2:0] idx, idx_nxt, idx_prev;

  // slot 7 holds S1 (the MSB chunk/nibble), so S-box idx lives in slot ~idx
  logic [SBOX_COUNT-1:0][SBOX_IN_W-1:0]  word, word_nxt;
  logic [SBOX_COUNT-1:0][SBOX_OUT_W-1:0] acc,  acc_nxt;

  logic [SBOX_IN_W-1:0]  rom_addr;
  logic [SBOX_OUT_W-1:0] rom_dout;

  assign rom_addr = word[~idx];
  assign idx_prev = idx - 3'd1;

  des_sbox_rom #(.REG_ROM(REG_ROM)) u_rom (
    .clk  (clk),
    .rst_n(rst_n),
    .sel  (idx),
    .addr (rom_addr),
    .dout (rom_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      word  <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      word  <= word_nxt;
      acc   <= acc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    word_nxt  = word;
    acc_nxt   = acc;
    case (state)
      S_IDLE: begin
        if (in_if.valid) begin
          word_nxt  = in_if.data;
          idx_nxt   = '0;
          acc_nxt   = '0;
          state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        // Registered lookup returns the previous cycle's S-box, so the
        // first cycle has nothing to write and S8 lands in DRAIN.
        if (!REG_ROM)            acc_nxt[~idx]      = rom_dout;
        else if (idx != 3'd0)    acc_nxt[~idx_prev] = rom_dout;
        if (idx == 3'(SBOX_COUNT - 1)) state_nxt = REG_ROM ? S_DRAIN : S_DONE;
        else                           idx_nxt   = idx + 3'd1;
      end
      S_DRAIN: begin
        acc_nxt[0] = rom_dout;
        state_nxt  = S_DONE;
      end
      S_DONE: begin
        if (out_if.ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_if.ready  = (state == S_IDLE);
  assign out_if.valid = (state == S_DONE);
  assign out_if.data  = acc;
  assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// tb_des_sbox_sequencer: directed checks of the serial S-box sequencer.
module tb_des_sbox_sequencer;
  localparam bit REG_ROM = 1'b0;
  localparam int LAT     = REG_ROM ? 9 : 8;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   failures;

  des_sbox_sequencer_if #(.W(48)) in_if ();
  des_sbox_sequencer_if #(.W(32)) out_if ();

  des_sbox_sequencer #(.REG_ROM(REG_ROM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_if (in_if),
    .out_if(out_if),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic run_word(input logic [47:0] d, input logic [31:0] exp);
    int k;
    @(negedge clk);
    checks++;
    if (in_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready: got %b want 1", in_if.ready);
    end
    in_if.valid = 1'b1;
    in_if.data  = d;
    @(negedge clk);
    in_if.valid = 1'b0;
    in_if.data  = ~d;
    k = 0;
    while (out_if.valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== LAT) begin
      failures++;
      $display("FAIL latency: got %0d want %0d", k, LAT);
    end
    checks++;
    if (out_if.data !== exp) begin
      failures++;
      $display("FAIL data(%h): got %h want %h", d, out_if.data, exp);
    end
    @(negedge clk);
    checks++;
    if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL handoff: got valid=%b ready=%b want 0/1", out_if.valid, in_if.ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (in_if.ready !== 1'b1 || out_if.valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b busy=%b want 1/0/0",
               in_if.ready, out_if.valid, busy);
    end
    checks++;
    if (out_if.data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got %h want 00000000", out_if.data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_if.ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: got ready=%b busy=%b want 1/0", in_if.ready, busy);
    end
  endtask

  task automatic test_vectors();
    run_word(48'h000000000000, 32'hEFA72C4D);
    run_word(48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
    // S5 alone at row 0 col 1
    run_word(48'h000000080000, 32'hEFA7CC4D);
    // S1 row 3 col 0, S8 row 0 col 15
    run_word(48'h84000000001E, 32'hFFA72C47);
  endtask

  task automatic test_back_pressure();
    int k;
    @(negedge clk);
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.data   = '0;
    @(negedge clk);
    in_if.valid = 1'b0;
    in_if.data  = 48'h123456789ABC;
    k = 0;
    while (out_if.valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== LAT || out_if.data !== 32'hEFA72C4D) begin
      failures++;
      $display("FAIL bp_first: got lat=%0d data=%h want %0d/EFA72C4D", k, out_if.data, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = '1;
      @(negedge clk);
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== 32'hEFA72C4D || in_if.ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b want 1/EFA72C4D/0",
                 i, out_if.valid, out_if.data, in_if.ready);
      end
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got valid=%b ready=%b busy=%b want 0/1/0",
               out_if.valid, in_if.ready, busy);
    end
    @(negedge clk);
    checks++;
    if (in_if.ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_accept: got ready=%b busy=%b want 1/0", in_if.ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    in_if.valid = 1'b1;
    in_if.data  = '1;
    @(negedge clk);
    in_if.valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_if.ready !== 1'b1 || out_if.valid !== 1'b0 || busy !== 1'b0 || out_if.data !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: got ready=%b valid=%b busy=%b data=%h want 1/0/0/00000000",
               in_if.ready, out_if.valid, busy, out_if.data);
    end
    bad = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL mid_no_pulse: got %0d bad cycles want 0", bad);
    end
    run_word(48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
  endtask

  task automatic test_back_to_back();
    int na, no;
    int acc_cyc [2];
    int out_cyc [2];
    logic [31:0] got [2];
    na = 0;
    no = 0;
    acc_cyc = '{-1, -1};
    out_cyc = '{-1, -1};
    got     = '{32'h0, 32'h0};
    out_if.ready = 1'b1;
    for (int c = 0; c < 80 && no < 2; c++) begin
      @(negedge clk);
      if (na == 0) begin
        in_if.valid = 1'b1;
        in_if.data  = 48'h84000000001E;
      end else if (na == 1) begin
        in_if.data = 48'h000000080000;
      end else begin
        in_if.valid = 1'b0;
      end
      if (in_if.valid && in_if.ready && na < 2) begin
        acc_cyc[na] = c;
        na++;
      end
      if (out_if.valid && no < 2) begin
        got[no]     = out_if.data;
        out_cyc[no] = c;
        no++;
      end
    end
    in_if.valid = 1'b0;
    checks++;
    if (no !== 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d results want 2", no);
    end
    checks++;
    if (got[0] !== 32'hFFA72C47) begin
      failures++;
      $display("FAIL b2b_first: got %h want FFA72C47", got[0]);
    end
    checks++;
    if (got[1] !== 32'hEFA7CC4D) begin
      failures++;
      $display("FAIL b2b_second: got %h want EFA7CC4D", got[1]);
    end
    checks++;
    if (out_cyc[0] - acc_cyc[0] !== LAT + 1) begin
      failures++;
      $display("FAIL b2b_latency: got %0d want %0d", out_cyc[0] - acc_cyc[0], LAT + 1);
    end
    checks++;
    if (acc_cyc[1] !== out_cyc[0] + 1) begin
      failures++;
      $display("FAIL b2b_accept_order: got accept@%0d want %0d", acc_cyc[1], out_cyc[0] + 1);
    end
  endtask

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    checks       = 0;
    failures     = 0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b1;
    test_reset();
    test_vectors();
    test_back_pressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
